// File: rtl/div_iter_pkg.sv
// div_iter_pkg -- shared definitions for the iterative divider.
//   div_state_e        : FSM state encoding (FREE, BYZERO, ON, END)
//   DIV_START/DIV_STOP : levels of the start request
//   DIV_RESULT_READY / DIV_RESULT_NOT_READY : levels of ready_o
package div_iter_pkg;

  typedef enum logic [1:0] {
    DIV_FREE   = 2'd0,
    DIV_BYZERO = 2'd1,
    DIV_ON     = 2'd2,
    DIV_END    = 2'd3
  } div_state_e;

  localparam logic DIV_START            = 1'b1;
  localparam logic DIV_STOP             = 1'b0;
  localparam logic DIV_RESULT_READY     = 1'b1;
  localparam logic DIV_RESULT_NOT_READY = 1'b0;

endpackage

// File: rtl/div_iter_step.sv
// div_step -- one combinational restoring-division step.
//   rem_i     : current partial remainder (WIDTH)
//   bit_i     : next dividend bit shifted in
//   divisor_i : divisor magnitude (WIDTH)
//   rem_o     : next partial remainder (WIDTH)
//   q_o       : quotient bit produced by this step
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic             bit_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] rem_o,
  output logic             q_o
);

  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] rem_sub;
  logic             sub_unused;

  assign shifted = {rem_i, bit_i};
  // When the subtraction is kept, shifted < 2*divisor, so the difference
  // always fits in WIDTH bits and the top bit can be dropped.
  assign {sub_unused, rem_sub} = shifted - {1'b0, divisor_i};
  assign q_o   = (shifted >= {1'b0, divisor_i});
  assign rem_o = q_o ? rem_sub : shifted[WIDTH-1:0];

endmodule

// File: rtl/div_iter.sv
// div_iter -- multi-cycle restoring divider (signed/unsigned), one quotient
// bit per cycle, WIDTH cycles per operation.
//   clk, rst      : clock, synchronous active-high reset
//   signed_div_i  : 1 = signed divide, 0 = unsigned
//   opdata1_i     : dividend
//   opdata2_i     : divisor
//   start_i       : request, held high until ready_o is seen
//   annul_i       : abort the operation in flight
//   result_o      : {remainder, quotient}, zero unless ready_o
//   ready_o       : result valid this cycle
// Build option: DIV_ZERO_DETECT_EN -- short-circuit a zero divisor through
// BYZERO to END with a zero result (two cycles instead of WIDTH+1).
module div_iter
  import div_iter_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               signed_div_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  input  logic               start_i,
  input  logic               annul_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o
);

  localparam int            CW   = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  div_state_e       state_q, state_d;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] dvd_q;   // dividend bits shift out, quotient bits shift in
  logic [WIDTH-1:0] dvs_q;
  logic [WIDTH-1:0] rem_q;
  logic             neg_quo_q, neg_rem_q;
`ifdef DIV_ZERO_DETECT_EN
  logic             byzero_q;
`endif

  logic             accept;
  logic             stop_req;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH-1:0] rem_next;
  logic             q_bit;
  logic [WIDTH-1:0] quo_fix, rem_fix;

  assign accept   = (state_q == DIV_FREE) && (start_i == DIV_START) && !annul_i;
  assign stop_req = annul_i || (start_i == DIV_STOP);

  assign a_mag = (signed_div_i && opdata1_i[WIDTH-1]) ? -opdata1_i : opdata1_i;
  assign b_mag = (signed_div_i && opdata2_i[WIDTH-1]) ? -opdata2_i : opdata2_i;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_i     (rem_q),
    .bit_i     (dvd_q[WIDTH-1]),
    .divisor_i (dvs_q),
    .rem_o     (rem_next),
    .q_o       (q_bit)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= DIV_FREE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      DIV_FREE: begin
        if (accept) begin
`ifdef DIV_ZERO_DETECT_EN
          state_d = (opdata2_i == '0) ? DIV_BYZERO : DIV_ON;
`else
          state_d = DIV_ON;
`endif
        end
      end
`ifdef DIV_ZERO_DETECT_EN
      DIV_BYZERO: state_d = stop_req ? DIV_FREE : DIV_END;
`endif
      DIV_ON: begin
        if (stop_req)            state_d = DIV_FREE;
        else if (cnt_q == LAST)  state_d = DIV_END;
      end
      DIV_END: begin
        // Start held high keeps the result up; only a drop releases it.
        if (start_i == DIV_STOP) state_d = DIV_FREE;
      end
      default: state_d = DIV_FREE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      dvd_q     <= '0;
      dvs_q     <= '0;
      rem_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
`ifdef DIV_ZERO_DETECT_EN
      byzero_q  <= 1'b0;
`endif
    end else begin
      if (accept) begin
        cnt_q     <= '0;
        dvd_q     <= a_mag;
        dvs_q     <= b_mag;
        rem_q     <= '0;
        neg_quo_q <= signed_div_i && (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
        neg_rem_q <= signed_div_i && opdata1_i[WIDTH-1];
`ifdef DIV_ZERO_DETECT_EN
        byzero_q  <= (opdata2_i == '0);
`endif
      end else if (state_q == DIV_ON && !stop_req) begin
        cnt_q <= cnt_q + 1'b1;
        dvd_q <= {dvd_q[WIDTH-2:0], q_bit};
        rem_q <= rem_next;
      end
    end
  end

  // Sign fix-up on the magnitudes; the most-negative / -1 case wraps.
  assign quo_fix = neg_quo_q ? -dvd_q : dvd_q;
  assign rem_fix = neg_rem_q ? -rem_q : rem_q;

  always_comb begin
    ready_o  = DIV_RESULT_NOT_READY;
    result_o = '0;
    if (state_q == DIV_END) begin
      ready_o  = DIV_RESULT_READY;
      result_o = {rem_fix, quo_fix};
`ifdef DIV_ZERO_DETECT_EN
      if (byzero_q) result_o = '0;
`endif
    end
  end

endmodule

// File: tb/tb_div_iter.sv
// tb_div_iter -- directed self-checking bench for div_iter (WIDTH = 32).
// Expected results are hand-computed; zero-divisor expectations follow the
// DIV_ZERO_DETECT_EN build option.
module tb_div_iter;

  logic        clk = 1'b0;
  logic        rst;
  logic        signed_div_i;
  logic [31:0] opdata1_i, opdata2_i;
  logic        start_i, annul_i;
  logic [63:0] result_o;
  logic        ready_o;

  int n_chk  = 0;
  int n_fail = 0;

  div_iter #(.WIDTH(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div_i),
    .opdata1_i    (opdata1_i),
    .opdata2_i    (opdata2_i),
    .start_i      (start_i),
    .annul_i      (annul_i),
    .result_o     (result_o),
    .ready_o      (ready_o)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drives a request in the current cycle (cycle 0) and counts cycles until
  // ready_o; returns 100 if it never comes. start_i is left high.
  task automatic run_div(input logic sg, input logic [31:0] a, input logic [31:0] b,
                         output int lat);
    signed_div_i = sg;
    opdata1_i    = a;
    opdata2_i    = b;
    start_i      = 1'b1;
    lat          = 0;
    while (lat < 100) begin
      tick();
      lat++;
      if (ready_o) break;
    end
  endtask

  task automatic release_op;
    start_i = 1'b0;
    tick();
  endtask

  initial begin
    int   lat;
    logic seen;

    rst = 1'b1; signed_div_i = 1'b0; opdata1_i = '0; opdata2_i = '0;
    start_i = 1'b0; annul_i = 1'b0;
    repeat (3) tick();
    check("reset_ready", {63'd0, ready_o}, 64'd0);
    check("reset_result", result_o, 64'd0);
    rst = 1'b0;
    tick();

    // unsigned 100 / 7 = 14 r 2, result held while start stays high
    run_div(1'b0, 32'd100, 32'd7, lat);
    check("u100_7_latency", 64'(lat), 64'd33);
    check("u100_7_result", result_o, {32'h2, 32'hE});
    tick(); tick();
    check("u100_7_hold_ready", {63'd0, ready_o}, 64'd1);
    check("u100_7_hold_result", result_o, {32'h2, 32'hE});
    release_op();
    check("u100_7_free_ready", {63'd0, ready_o}, 64'd0);
    check("u100_7_free_result", result_o, 64'd0);

    // signed -7 / 2 = -3 r -1
    run_div(1'b1, 32'hFFFFFFF9, 32'h2, lat);
    check("s_m7_2_latency", 64'(lat), 64'd33);
    check("s_m7_2_result", result_o, {32'hFFFFFFFF, 32'hFFFFFFFD});
    release_op();

    // signed 7 / -2 = -3 r 1
    run_div(1'b1, 32'h7, 32'hFFFFFFFE, lat);
    check("s_7_m2_result", result_o, {32'h1, 32'hFFFFFFFD});
    release_op();

    // signed -7 / -2 = 3 r -1
    run_div(1'b1, 32'hFFFFFFF9, 32'hFFFFFFFE, lat);
    check("s_m7_m2_result", result_o, {32'hFFFFFFFF, 32'h3});
    release_op();

    // signed overflow wraps
    run_div(1'b1, 32'h80000000, 32'hFFFFFFFF, lat);
    check("s_ovf_result", result_o, {32'h0, 32'h80000000});
    release_op();

    // unsigned max / 1
    run_div(1'b0, 32'hFFFFFFFF, 32'h1, lat);
    check("u_max_1_result", result_o, {32'h0, 32'hFFFFFFFF});
    release_op();

    // annul together with start in FREE: request must be dropped
    signed_div_i = 1'b0; opdata1_i = 32'd50; opdata2_i = 32'd5;
    start_i = 1'b1; annul_i = 1'b1;
    tick();
    start_i = 1'b0; annul_i = 1'b0;
    seen = 1'b0;
    repeat (40) begin tick(); seen |= ready_o; end
    check("annul_in_free_no_ready", {63'd0, seen}, 64'd0);

    // annul in cycle 10 of an operation; a new 9/3 is accepted in cycle 11
    signed_div_i = 1'b0; opdata1_i = 32'd100; opdata2_i = 32'd7; start_i = 1'b1;
    seen = 1'b0;
    repeat (10) begin tick(); seen |= ready_o; end
    annul_i = 1'b1;
    tick();
    seen |= ready_o;
    annul_i = 1'b0;
    run_div(1'b0, 32'd9, 32'd3, lat);
    check("annul_no_ready", {63'd0, seen}, 64'd0);
    check("after_annul_latency", 64'(lat), 64'd33);
    check("after_annul_result", result_o, {32'h0, 32'h3});
    release_op();

    // zero divisor
    run_div(1'b0, 32'd5, 32'd0, lat);
`ifdef DIV_ZERO_DETECT_EN
    check("div0_latency", 64'(lat), 64'd2);
    check("div0_result", result_o, 64'd0);
`else
    check("div0_latency", 64'(lat), 64'd33);
    check("div0_result", result_o, {32'h5, 32'hFFFFFFFF});
`endif
    release_op();

    // reset in cycle 20 of an operation
    signed_div_i = 1'b0; opdata1_i = 32'd100; opdata2_i = 32'd7; start_i = 1'b1;
    repeat (20) tick();
    rst = 1'b1;
    tick();
    check("rst_mid_ready", {63'd0, ready_o}, 64'd0);
    check("rst_mid_result", result_o, 64'd0);
    rst = 1'b0; start_i = 1'b0;
    seen = 1'b0;
    repeat (40) begin tick(); seen |= ready_o; end
    check("rst_mid_no_ready", {63'd0, seen}, 64'd0);

    // normal operation after reset
    run_div(1'b0, 32'd1000, 32'd33, lat);
    check("post_rst_latency", 64'(lat), 64'd33);
    check("post_rst_result", result_o, {32'd10, 32'd30});
    release_op();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
